// File: rtl/sa_weight_addr_gen.sv
// sa_weight_addr_gen: walks an N x N weight tile row-major or transposed, one address per accepted beat.
// Optional back-to-back tiles without a DONE bubble when SA_WADDR_B2B_EN is defined.
module sa_weight_addr_gen #(
    parameter int N      = 3,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SW = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAXI = CNT_W'(N - 1);
    state_t            r_state;
    logic [CNT_W-1:0]  r_i, r_j;
    logic              r_mode;
    logic [ADDR_W-1:0] r_base;
    logic              w_fire, w_wrap, w_b2b, w_load;
    logic [CNT_W-1:0]  w_ni, w_nj;
    logic [ADDR_W-1:0] w_naddr;

    // Sum kept one bit wider than the address, then truncated: wrap is silent.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic m, input logic [ADDR_W-1:0] b,
                                                    input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] j);
        logic [SW-1:0] major, minor, sum;
        major = m ? SW'(i) : SW'(j);
        minor = m ? SW'(j) : SW'(i);
        sum   = SW'(b) + major * SW'(N) + minor;
        return sum[ADDR_W-1:0];
    endfunction

    always_comb begin
        w_fire  = addr_valid & addr_ready;
        w_wrap  = r_i == MAXI;
        w_ni    = w_wrap ? '0 : r_i + 1'b1;
        w_nj    = w_wrap ? r_j + 1'b1 : r_j;
        w_naddr = tile_addr(r_mode, r_base, w_ni, w_nj);
`ifdef SA_WADDR_B2B_EN
        w_b2b   = start;
`else
        w_b2b   = 1'b0;
`endif
        w_load  = (r_state == IDLE && start) || (r_state == RUN && w_fire && last && w_b2b);
    end

    assign busy = r_state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_mode     <= 1'b0;
            r_base     <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= r_state == RUN && w_fire && last;
            if (w_load) begin
                r_state    <= RUN;
                r_mode     <= mode;
                r_base     <= base_addr;
                r_i        <= '0;
                r_j        <= '0;
                addr       <= base_addr;
                addr_valid <= 1'b1;
                last       <= 1'b0;
            end else if (r_state == RUN && w_fire && last) begin
                r_state    <= DONE;
                addr_valid <= 1'b0;
                last       <= 1'b0;
            end else if (r_state == RUN && w_fire) begin
                r_i  <= w_ni;
                r_j  <= w_nj;
                addr <= w_naddr;
                last <= (w_ni == MAXI) && (w_nj == MAXI);
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sa_weight_addr_gen.sv
// tb_sa_weight_addr_gen: table vectors, directed corner sequences and randomized tiles
// checked against an index-arithmetic model of the tile walk.
module tb_sa_weight_addr_gen;
    localparam int N  = 3;
    localparam int AW = 6;
    typedef int ev_t [N*N];
    typedef struct {
        bit  m;
        int  b;
        ev_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          addr_ready = 1'b0;
    logic          addr_valid, last, busy, done;
    logic [AW-1:0] addr;
    int            n_cmp = 0;
    int            n_bad = 0;
    vec_t          tbl [4];

    sa_weight_addr_gen #(.N(N), .ADDR_W(AW), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
        .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr), .last(last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Beat k sits at row k/N, column k%N of the tile; transposed reads column-first.
    function automatic ev_t model(input bit m, input int b);
        ev_t r;
        for (int k = 0; k < N*N; k++)
            r[k] = (b + (m ? (k % N) * N + k / N : k)) % (1 << AW);
        return r;
    endfunction

    task automatic launch(input bit m, input int b);
        start = 1'b1;
        mode = m;
        base_addr = AW'(b);
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom);
        base_addr = AW'($urandom);
    endtask

    // Entered #1 after the edge that started the tile; leaves #1 after the last beat's edge.
    task automatic run_tile(input ev_t exp, input int rmode, input bit noise, input bit d0,
                            input bit chain, input bit cm, input int cb);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        bit rdy;
        while (k < N*N && cyc < 200) begin
            chk("valid", addr_valid, 1);
            chk("addr", addr, exp[k]);
            chk("last", last, k == N*N-1);
            chk("busy", busy, 1);
            chk("done", done, d0 && cyc == 0);
            rdy = rmode == 1 ? $urandom_range(0, 3) != 0 : !(rmode == 2 && k == 3 && stall < 3);
            if (!rdy && rmode == 2) stall++;
            addr_ready = rdy;
            start = noise && !(rdy && k == N*N-1) ? 1'($urandom) : 1'b0;
            if (noise) begin
                mode = 1'($urandom);
                base_addr = AW'($urandom);
            end
            if (chain && rdy && k == N*N-1) begin
                start = 1'b1;
                mode = cm;
                base_addr = AW'(cb);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        if (k < N*N) chk("timeout", k, N*N);
    endtask

    task automatic finish_tile(input bit noise);
        chk("done_pulse", done, 1);
        chk("done_valid", addr_valid, 0);
        chk("done_last", last, 0);
        chk("done_busy", busy, 1);
        start = noise;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", addr_valid, 0);
    endtask

    initial begin
        tbl[0].m = 1; tbl[0].b = 0;  tbl[0].exp = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        tbl[1].m = 0; tbl[1].b = 16; tbl[1].exp = '{16, 17, 18, 19, 20, 21, 22, 23, 24};
        tbl[2].m = 0; tbl[2].b = 60; tbl[2].exp = '{60, 61, 62, 63, 0, 1, 2, 3, 4};
        tbl[3].m = 1; tbl[3].b = 62; tbl[3].exp = '{62, 1, 4, 63, 2, 5, 0, 3, 6};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            launch(tbl[t].m, tbl[t].b);
            run_tile(tbl[t].exp, 0, 0, 0, 0, 0, 0);
            finish_tile(0);
        end

        launch(1, 0);
        run_tile(tbl[0].exp, 2, 0, 0, 0, 0, 0);
        finish_tile(0);

        // Start arriving in RUN and DONE must be ignored.
        for (int t = 0; t < 20; t++) begin
            bit m;
            int b;
            m = 1'($urandom);
            b = int'($urandom_range(0, (1 << AW) - 1));
            launch(m, b);
            run_tile(model(m, b), 1, 1, 0, 0, 0, 0);
            finish_tile(1);
        end

        launch(0, 32);
        addr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_addr", addr, 37);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", addr_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_last", last, 0);
        chk("abort_addr", addr, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        launch(0, 32);
        run_tile(model(0, 32), 0, 0, 0, 0, 0, 0);
        finish_tile(0);

        launch(1, 0);
        run_tile(tbl[0].exp, 0, 0, 0, 1, 0, 48);
`ifdef SA_WADDR_B2B_EN
        run_tile(model(0, 48), 0, 0, 1, 0, 0, 0);
        finish_tile(0);
`else
        finish_tile(0);
        chk("no_b2b_valid", addr_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
